// File: rtl/bitcnt_arbiter.sv
// Shared iterative bit-count unit (clz / ctz / cpop) serving two issue lanes.
// Requests are arbitrated round-robin, the operand is scanned STEP bits per
// cycle from the top, and one tagged result is returned per operation.
module bitcnt_arbiter #(
    parameter int XLEN = 32,
    parameter int STEP = 4,
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            l0_valid,
    output logic            l0_ready,
    input  logic [1:0]      l0_op,
    input  logic [XLEN-1:0] l0_src,
    input  logic [TAGW-1:0] l0_tag,
    input  logic            l1_valid,
    output logic            l1_ready,
    input  logic [1:0]      l1_op,
    input  logic [XLEN-1:0] l1_src,
    input  logic [TAGW-1:0] l1_tag,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            resp_lane,
    output logic [TAGW-1:0] resp_tag,
    output logic [XLEN-1:0] resp_result,
    output logic            busy
);

    localparam int NCHUNK = XLEN / STEP;
    localparam int CW     = $clog2(XLEN) + 1;
    localparam int CHW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int LZW    = $clog2(STEP) + 1;

    localparam logic [1:0] OP_CLZ  = 2'b00;
    localparam logic [1:0] OP_CTZ  = 2'b01;
    localparam logic [1:0] OP_CPOP = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t            state_reg, state_next;
    logic              rr_ptr_reg, rr_ptr_next;
    logic [1:0]        op_reg, op_next;
    logic [TAGW-1:0]   tag_reg, tag_next;
    logic              lane_reg, lane_next;
    logic [XLEN-1:0]   shift_reg, shift_next;
    logic [CW-1:0]     count_reg, count_next;
    logic [CHW-1:0]    chunk_reg, chunk_next;
    logic              resp_valid_reg, resp_valid_next;
    logic              resp_lane_reg, resp_lane_next;
    logic [TAGW-1:0]   resp_tag_reg, resp_tag_next;
    logic [XLEN-1:0]   resp_result_reg, resp_result_next;

    logic              grant_lane;
    logic              accept;
    logic [XLEN-1:0]   sel_src;
    logic [XLEN-1:0]   sel_src_rev;
    logic [1:0]        sel_op;
    logic [STEP-1:0]   chunk_bits;
    logic [LZW-1:0]    chunk_lz;
    logic [LZW-1:0]    chunk_pop;
    logic              chunk_found;
    logic              last_chunk;

    // ctz is computed as clz of the bit-reversed operand
    assign sel_src = grant_lane ? l1_src : l0_src;
    assign sel_op  = grant_lane ? l1_op  : l0_op;
    for (genvar gi = 0; gi < XLEN; gi++) begin : g_rev
        assign sel_src_rev[gi] = sel_src[XLEN-1-gi];
    end

    assign chunk_bits = shift_reg[XLEN-1 -: STEP];
    assign last_chunk = (chunk_reg == CHW'(NCHUNK - 1));

    // Leading-zero count and population count of the chunk under examination
    always_comb begin
        chunk_lz    = '0;
        chunk_pop   = '0;
        chunk_found = 1'b0;
        for (int i = STEP - 1; i >= 0; i--) begin
            chunk_pop = chunk_pop + LZW'(chunk_bits[i]);
            if (!chunk_found) begin
                if (chunk_bits[i]) chunk_found = 1'b1;
                else               chunk_lz    = chunk_lz + LZW'(1);
            end
        end
    end

    // Arbitration, handshakes and next-state logic
    always_comb begin
        state_next       = state_reg;
        rr_ptr_next      = rr_ptr_reg;
        op_next          = op_reg;
        tag_next         = tag_reg;
        lane_next        = lane_reg;
        shift_next       = shift_reg;
        count_next       = count_reg;
        chunk_next       = chunk_reg;
        resp_valid_next  = resp_valid_reg;
        resp_lane_next   = resp_lane_reg;
        resp_tag_next    = resp_tag_reg;
        resp_result_next = resp_result_reg;

        grant_lane = (l0_valid && l1_valid) ? rr_ptr_reg : l1_valid;
        l0_ready   = (state_reg == ST_IDLE) && !flush && l0_valid && !grant_lane;
        l1_ready   = (state_reg == ST_IDLE) && !flush && l1_valid && grant_lane;
        accept     = l0_ready || l1_ready;

        if (flush) begin
            state_next      = ST_IDLE;
            resp_valid_next = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        op_next     = sel_op;
                        tag_next    = grant_lane ? l1_tag : l0_tag;
                        lane_next   = grant_lane;
                        shift_next  = (sel_op == OP_CTZ) ? sel_src_rev : sel_src;
                        count_next  = '0;
                        chunk_next  = '0;
                        rr_ptr_next = ~grant_lane;
                        state_next  = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (op_reg == OP_CLZ || op_reg == OP_CTZ) begin
                        if (chunk_bits != '0) begin
                            count_next = count_reg + CW'(chunk_lz);
                            state_next = ST_DONE;
                        end else begin
                            count_next = count_reg + CW'(STEP);
                            shift_next = shift_reg << STEP;
                            chunk_next = chunk_reg + CHW'(1);
                            if (last_chunk) state_next = ST_DONE;
                        end
                    end else if (op_reg == OP_CPOP) begin
                        count_next = count_reg + CW'(chunk_pop);
                        shift_next = shift_reg << STEP;
                        chunk_next = chunk_reg + CHW'(1);
                        if (last_chunk) state_next = ST_DONE;
                    end else begin
                        // reserved opcode: result stays zero
                        state_next = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!resp_valid_reg) begin
                        resp_valid_next  = 1'b1;
                        resp_lane_next   = lane_reg;
                        resp_tag_next    = tag_reg;
                        resp_result_next = {{(XLEN-CW){1'b0}}, count_reg};
                    end else if (resp_ready) begin
                        resp_valid_next = 1'b0;
                        state_next      = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            rr_ptr_reg      <= 1'b0;
            op_reg          <= '0;
            tag_reg         <= '0;
            lane_reg        <= 1'b0;
            shift_reg       <= '0;
            count_reg       <= '0;
            chunk_reg       <= '0;
            resp_valid_reg  <= 1'b0;
            resp_lane_reg   <= 1'b0;
            resp_tag_reg    <= '0;
            resp_result_reg <= '0;
        end else begin
            state_reg       <= state_next;
            rr_ptr_reg      <= rr_ptr_next;
            op_reg          <= op_next;
            tag_reg         <= tag_next;
            lane_reg        <= lane_next;
            shift_reg       <= shift_next;
            count_reg       <= count_next;
            chunk_reg       <= chunk_next;
            resp_valid_reg  <= resp_valid_next;
            resp_lane_reg   <= resp_lane_next;
            resp_tag_reg    <= resp_tag_next;
            resp_result_reg <= resp_result_next;
        end
    end

    assign resp_valid  = resp_valid_reg;
    assign resp_lane   = resp_lane_reg;
    assign resp_tag    = resp_tag_reg;
    assign resp_result = resp_result_reg;
    assign busy        = (state_reg != ST_IDLE);

endmodule

// File: doc/bitcnt_arbiter.md
Name: bitcnt_arbiter

Overview:
- Sequences one shared iterative bit-count unit (clz, ctz, cpop: the "count" ALU operation class) and shares it between the two issue lanes of the dual-issue core.
- Round-robin arbitration between lanes, each using a valid/ready request handshake.
- Processes STEP bits per cycle, with early termination for clz/ctz.
- Returns one tagged result per operation over a valid/ready response handshake to the writeback arbitration.

Parameters:
- XLEN, 32, operand/result width.
- STEP, 4, bits examined per RUN cycle; must divide XLEN (legal: 1, 2, 4, 8).
- TAGW, 5, destination-register tag width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of the in-flight operation.
- l0_valid  in  1  lane 0 request valid.
- l0_ready  out  1  lane 0 request accepted this cycle (when l0_valid).
- l0_op  in  2  00 clz, 01 ctz, 10 cpop, 11 reserved.
- l0_src  in  XLEN  lane 0 operand.
- l0_tag  in  TAGW  lane 0 destination tag.
- l1_valid, l1_ready, l1_op, l1_src, l1_tag  as lane 0, for lane 1.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_lane  out  1  originating lane.
- resp_tag  out  TAGW  tag of the result.
- resp_result  out  XLEN  count, zero-extended.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr_ptr=0 (lane 0 preferred), resp_valid=0, resp_lane=0, resp_tag=0, resp_result=0, busy=0, internal count/shift/chunk registers 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - l0_ready/l1_ready are combinational from state, rr_ptr, valids and flush. Both ready are 0 outside IDLE or when flush=1.
  - One valid lane: that lane is granted.
  - Both valid: the lane equal to rr_ptr is granted.
  - On accept (valid&ready):
    - latch op, tag, lane;
    - shift reg = src for clz/cpop, bit-reversed src for ctz;
    - count=0, chunk=0;
    - rr_ptr = ~granted lane;
    - go RUN.
- RUN, each cycle examines the top STEP bits of the shift register:
  - clz/ctz: if the chunk is nonzero, count += leading zeros within the chunk, then go DONE. Otherwise count += STEP, shift left by STEP, chunk++.
  - cpop: count += popcount(chunk), shift, chunk++.
  - After chunk XLEN/STEP-1 is processed, go DONE regardless of result. An all-zero operand gives clz/ctz=XLEN, cpop=0.
  - op 11: result 0, go DONE after one RUN cycle.
- DONE:
  - resp_valid=1; resp_lane/resp_tag/resp_result are held stable until resp_ready.
  - On resp_valid&resp_ready: go IDLE and clear resp_valid.
  - No new accept in the same cycle; the next accept is possible one cycle later.
- Latency: an accept at edge E gives resp_valid high after edge E+N+1, where N = RUN cycles.
  - clz/ctz: N = index of the first chunk containing a 1, plus 1 (XLEN/STEP if none).
  - cpop: N = XLEN/STEP.
- Count register width: clog2(XLEN)+1 bits; the result is zero-extended to XLEN.
- flush=1 (priority over everything except reset):
  - next state IDLE, resp_valid=0 next cycle, in-flight result discarded;
  - rr_ptr unchanged;
  - no request accepted in the flush cycle.
- Request fields are sampled only at accept. Source changes after accept have no effect.
- Lane valid deasserting without ready is legal; no grant is recorded and rr_ptr is unchanged.
- Reset mid-operation: immediate return to reset values; no response is produced.

Test Plan:
- Lane 0 clz, src=0x00010000, STEP=4 -> resp_result=15, resp_lane=0, tag echoed, 4 RUN cycles, resp_valid 5 cycles after accept.
- Lane 1 ctz, src=0x00000008 -> resp_result=3, 1 RUN cycle. Then cpop, src=0xF0F00001 -> 9 after 8 RUN cycles.
- src=0 for clz, ctz, cpop -> 32, 32, 0, each after 8 RUN cycles. Then src=0xFFFFFFFF cpop -> 32; clz -> 0 after 1 RUN cycle.
- Both lanes continuously valid with distinct tags, resp_ready=1 -> grants alternate 0,1,0,1 from reset; resp_lane/resp_tag match grant order; no accept while busy=1.
- resp_ready held 0 for 5 cycles in DONE -> outputs stable, l0_ready=l1_ready=0; resp_ready=1 -> IDLE; accept on the following cycle.
- flush in the 2nd RUN cycle of a cpop -> resp_valid never rises, busy=0 next cycle, rr_ptr preserved. rst_n pulsed low mid-RUN -> all outputs reset immediately.
